mu0_mem_arbiter: RTL and testbench

Two-port memory arbiter that shares one synchronous single-port RAM between the MU0 CPU and the ackie debug interface. It replaces direct dual-port wiring: each requester raises a level request and receives a one-cycle acknowledge. Grants use round-robin on contention, so neither side can starve the other. Address, data and write-enable are captured at grant, and read data is held per port until that port's next read.

---
 rtl/mu0_mem_arbiter.sv | 91 +++++++++
 tb/tb_mu0_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the MU0 CPU
// and the ackie debug port; fixed IDLE/ISSUE/CAPTURE/ACK access sequence.
module mu0_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t state, state_nx;
    logic   grant;
    logic   grant_dbg;
    logic   ram_wen_q;

    always_comb begin
        grant     = cpu_req | dbg_req;
        // On contention the port that did not hold the last grant wins
        grant_dbg = dbg_req & (~cpu_req | ~owner);
        state_nx  = state;
        unique case (state)
            IDLE:    if (grant) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = ACK;
            ACK:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b1;
            ram_en    <= 1'b0;
            ram_wen   <= 1'b0;
            ram_wen_q <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx != IDLE);
            ram_en  <= (state == IDLE) && grant;
            ram_wen <= (state == IDLE) && grant && (grant_dbg ? dbg_wen : cpu_wen);
            cpu_ack <= (state == CAPTURE) && !owner;
            dbg_ack <= (state == CAPTURE) && owner;

            if (state == IDLE && grant) begin
                owner     <= grant_dbg;
                ram_wen_q <= grant_dbg ? dbg_wen   : cpu_wen;
                ram_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                ram_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            end

            if (state == CAPTURE && !ram_wen_q) begin
                if (owner) dbg_rdata <= ram_rdata;
                else       cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Directed bench for mu0_mem_arbiter with a behavioural RAM and per-port
// scoreboard queues of expected read data checked on each ack.
module tb_mu0_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wen, dbg_req, dbg_wen;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_ack, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          ram_en, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy, owner;

    always #5 clk = ~clk;

    mu0_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(a) * 16'h0101 ^ 16'h5A5A;
    endfunction

    // Synchronous RAM; unwritten locations return a fixed address pattern
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) begin
                ram[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? ram[ram_addr] : pattern(ram_addr);
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] dbg_q[$];
    logic [DW-1:0] cpu_hold = '0;
    logic [DW-1:0] dbg_hold = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_ack) begin
                if (cpu_q.size() == 0) check("cpu_ack_spurious", 32'(cpu_q.size()), 32'd1);
                else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
            end
            if (dbg_ack) begin
                if (dbg_q.size() == 0) check("dbg_ack_spurious", 32'(dbg_q.size()), 32'd1);
                else check("dbg_rdata", 32'(dbg_rdata), 32'(dbg_q.pop_front()));
            end
            if (ram_wen) check("ram_wen_needs_en", 32'(ram_en), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit wen,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            dbg_req = req; dbg_wen = wen; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = req; cpu_wen = wen; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    task automatic expect_access(input bit port, input bit wen,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (wen) ref_mem[a] = d;
        else if (port) dbg_hold = ref_mem[a];
        else cpu_hold = ref_mem[a];
        if (port) dbg_q.push_back(dbg_hold);
        else cpu_q.push_back(cpu_hold);
    endtask

    // One uncontended access starting with the FSM in IDLE
    task automatic single(input bit port, input bit wen, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit drop_early);
        drive(port, 1'b1, wen, a, d);
        expect_access(port, wen, a, d);
        tick();
        check("issue_ram_en", 32'(ram_en), 32'd1);
        check("issue_ram_wen", 32'(ram_wen), 32'(wen));
        check("issue_ram_addr", 32'(ram_addr), 32'(a));
        if (wen) check("issue_ram_wdata", 32'(ram_wdata), 32'(d));
        check("issue_owner", 32'(owner), 32'(port));
        check("issue_busy", 32'(busy), 32'd1);
        if (drop_early) drive(port, 1'b0, 1'b0, '0, '0);
        tick();
        check("capture_ram_en", 32'(ram_en), 32'd0);
        check("capture_no_ack", 32'(cpu_ack | dbg_ack), 32'd0);
        tick();
        check("ack_owner", 32'(port ? dbg_ack : cpu_ack), 32'd1);
        check("ack_other", 32'(port ? cpu_ack : dbg_ack), 32'd0);
        drive(port, 1'b0, 1'b0, '0, '0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'(cpu_ack | dbg_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int cpu_at, dbg_at, n_acc, ci, di, cpu_pres, dbg_pres, n_ack;
        bit exp_port;
        int en_cyc[$];

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(AW'(i));
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);

        // Reset while a CPU read is in ISSUE: dropped, no ack
        drive(1'b0, 1'b1, 1'b0, 12'h003, '0);
        tick();
        check("midrst_issue_en", 32'(ram_en), 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ram_en", 32'(ram_en), 32'd0);
        check("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("midrst_owner", 32'(owner), 32'd1);
        check("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        tick(); tick(); tick();
        check("midrst_no_late_ack", 32'(cpu_ack), 32'd0);

        // CPU write then read back
        single(1'b0, 1'b1, 12'h005, 16'hBEEF, 1'b0);
        check("wr_cpu_rdata_held", 32'(cpu_rdata), 32'd0);
        single(1'b0, 1'b0, 12'h005, '0, 1'b0);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

        // Contention from reset: CPU first, ackie next
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cont_owner_rst", 32'(owner), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 12'h001, '0);
        drive(1'b1, 1'b1, 1'b0, 12'h002, '0);
        expect_access(1'b0, 1'b0, 12'h001, '0);
        expect_access(1'b1, 1'b0, 12'h002, '0);
        cpu_at = -1; dbg_at = -1; cpu_pres = cyc;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cpu_ack && cpu_at < 0) begin cpu_at = cyc - cpu_pres; drive(1'b0, 1'b0, 1'b0, '0, '0); end
            if (dbg_ack && dbg_at < 0) begin dbg_at = cyc - cpu_pres; drive(1'b1, 1'b0, 1'b0, '0, '0); end
        end
        check("cont_cpu_ack_cycle", 32'(cpu_at), 32'd3);
        check("cont_dbg_ack_cycle", 32'(dbg_at), 32'd7);

        // Continuous contention: grants alternate, bounded wait
        n_acc = 0; ci = 0; di = 0; exp_port = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h020, '0);
        expect_access(1'b0, 1'b0, 12'h020, '0);
        drive(1'b1, 1'b1, 1'b0, 12'h030, '0);
        expect_access(1'b1, 1'b0, 12'h030, '0);
        cpu_pres = cyc; dbg_pres = cyc;
        for (int k = 0; k < 60 && n_acc < 8; k++) begin
            tick();
            if (cpu_ack || dbg_ack) begin
                check("alt_port", 32'(dbg_ack), 32'(exp_port));
                exp_port = ~exp_port;
                n_acc++;
                if (cpu_ack) begin
                    check("alt_cpu_wait", 32'((cyc - cpu_pres) <= 8), 32'd1);
                    ci++;
                    if (ci < 4) begin
                        drive(1'b0, 1'b1, 1'b0, AW'(12'h020 + ci), '0);
                        expect_access(1'b0, 1'b0, AW'(12'h020 + ci), '0);
                        cpu_pres = cyc;
                    end else drive(1'b0, 1'b0, 1'b0, '0, '0);
                end
                if (dbg_ack) begin
                    check("alt_dbg_wait", 32'((cyc - dbg_pres) <= 8), 32'd1);
                    di++;
                    if (di < 4) begin
                        drive(1'b1, 1'b1, 1'b0, AW'(12'h030 + di), '0);
                        expect_access(1'b1, 1'b0, AW'(12'h030 + di), '0);
                        dbg_pres = cyc;
                    end else drive(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check("alt_count", 32'(n_acc), 32'd8);
        tick();

        // ackie read result held across CPU writes
        single(1'b1, 1'b1, 12'h010, 16'h1234, 1'b0);
        single(1'b1, 1'b0, 12'h010, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            single(1'b0, 1'b1, AW'(12'h040 + i), DW'(16'hA000 + i), 1'b0);
            check("hold_dbg_rdata", 32'(dbg_rdata), 32'h1234);
        end

        // Request dropped in cycle 1 still completes
        single(1'b0, 1'b1, 12'h7FF, 16'hCAFE, 1'b1);
        single(1'b0, 1'b0, 12'h7FF, '0, 1'b0);
        check("drop_readback", 32'(cpu_rdata), 32'hCAFE);

        // Back-to-back reads with cpu_req held
        n_ack = 0;
        drive(1'b0, 1'b1, 1'b0, 12'h100, '0);
        expect_access(1'b0, 1'b0, 12'h100, '0);
        for (int k = 0; k < 30 && n_ack < 3; k++) begin
            tick();
            if (ram_en) en_cyc.push_back(cyc);
            if (cpu_ack) begin
                n_ack++;
                if (n_ack < 3) begin
                    drive(1'b0, 1'b1, 1'b0, AW'(12'h100 + n_ack), '0);
                    expect_access(1'b0, 1'b0, AW'(12'h100 + n_ack), '0);
                end else drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        check("b2b_acks", 32'(n_ack), 32'd3);
        check("b2b_en_pulses", 32'(en_cyc.size()), 32'd3);
        for (int i = 1; i < en_cyc.size(); i++)
            check("b2b_en_spacing", 32'(en_cyc[i] - en_cyc[i-1]), 32'd4);

        tick(); tick(); tick(); tick();
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
